// File: rtl/saucer_ride_ctrl.sv
// Saucer ride controller: Qbert boards a moving saucer, follows it, drops step-wise
// onto the pyramid top cube, lands, then hands control back to the jump controller.
module saucer_ride_ctrl #(
    parameter logic [9:0]  HOVER       = 10'd8,
    parameter int          LAND_CYCLES = 16,
    parameter logic [31:0] DF_SPEED    = 32'd100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_pause_qb,
    input  logic        e_resume_qb,
    input  logic        e_start_qb,
    input  logic [31:0] e_speed_qb,
    input  logic [20:0] e_XY0_qb,
    input  logic [20:0] soucoupe_xy,
    input  logic        qb_on_sc,
    input  logic        done_move_sc,
    input  logic        mode_saucer,
    input  logic [1:0]  state_sc,
    output logic [20:0] ride_xy,
    output logic        qb_lock,
    output logic        ride_done,
    output logic [2:0]  ride_state
);

    typedef enum logic [1:0] {
        G_RESUME  = 2'd0,
        G_PAUSE   = 2'd1,
        G_RESTART = 2'd2
    } game_t;

    typedef enum logic [2:0] {
        R_IDLE = 3'd0,
        R_RIDE = 3'd1,
        R_DROP = 3'd2,
        R_LAND = 3'd3
    } ride_t;

    localparam logic [1:0]  SC_MOVE   = 2'd1;
    localparam logic [1:0]  SC_END    = 2'd2;
    localparam logic [31:0] LAND_LAST = 32'(LAND_CYCLES - 1);

    game_t       game_q, game_n;
    ride_t       ride_q, ride_n;
    logic [20:0] xy_n;
    logic        lock_n;
    logic        done_n;
    logic [31:0] count_q, count_n;
    logic [31:0] speed_q, speed_n;
    logic        armed_q, armed_n;

    // Follow position: saucer centre raised by HOVER, clamped at the top of the screen.
    logic [10:0] sc_x;
    logic [9:0]  sc_y;
    logic [9:0]  follow_y;
    logic [20:0] follow_xy;

    assign sc_x      = soucoupe_xy[20:10];
    assign sc_y      = soucoupe_xy[9:0];
    assign follow_y  = (sc_y < HOVER) ? 10'd0 : sc_y - HOVER;
    assign follow_xy = {sc_x, follow_y};

    // One unit step of each axis toward the landing cube.
    logic [10:0] cur_x, tgt_x, step_x;
    logic [9:0]  cur_y, tgt_y, step_y;
    logic [20:0] stepped_xy;

    assign cur_x = ride_xy[20:10];
    assign cur_y = ride_xy[9:0];
    assign tgt_x = e_XY0_qb[20:10];
    assign tgt_y = e_XY0_qb[9:0];

    always_comb begin
        if (cur_x < tgt_x)
            step_x = cur_x + 11'd1;
        else if (cur_x > tgt_x)
            step_x = cur_x - 11'd1;
        else
            step_x = cur_x;

        if (cur_y < tgt_y)
            step_y = cur_y + 10'd1;
        else if (cur_y > tgt_y)
            step_y = cur_y - 10'd1;
        else
            step_y = cur_y;
    end

    assign stepped_xy = {step_x, step_y};

    logic [31:0] speed_sel;
    assign speed_sel = (e_speed_qb != 32'd0) ? e_speed_qb : DF_SPEED;

    logic board_ok;
    assign board_ok = armed_q && mode_saucer && qb_on_sc && (state_sc == SC_MOVE);

    always_comb begin
        // NOTE: every next-state value is defaulted to "hold" first so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        game_n  = game_q;
        ride_n  = ride_q;
        xy_n    = ride_xy;
        lock_n  = qb_lock;
        done_n  = 1'b0;
        count_n = count_q;
        speed_n = speed_q;
        armed_n = armed_q;

        case (game_q)
            G_PAUSE: begin
                if (e_resume_qb)
                    game_n = G_RESUME;
                else if (e_start_qb)
                    game_n = G_RESTART;
            end

            G_RESTART: begin
                speed_n = speed_sel;
                ride_n  = R_IDLE;
                xy_n    = 21'd0;
                count_n = 32'd0;
                lock_n  = 1'b0;
                armed_n = 1'b1;
                game_n  = G_RESUME;
            end

            G_RESUME: begin
                speed_n = speed_sel;
                if (e_pause_qb) begin
                    game_n = G_PAUSE;
                end else begin
                    case (ride_q)
                        R_IDLE: begin
                            lock_n = 1'b0;
                            if (!qb_on_sc)
                                armed_n = 1'b1;
                            if (board_ok) begin
                                ride_n = R_RIDE;
                                lock_n = 1'b1;
                                xy_n   = follow_xy;
                            end
                        end

                        R_RIDE: begin
                            if (!mode_saucer) begin
                                ride_n = R_IDLE;
                                lock_n = 1'b0;
                            end else begin
                                xy_n = follow_xy;
                                if (state_sc == SC_END || done_move_sc) begin
                                    ride_n  = R_DROP;
                                    count_n = 32'd0;
                                end
                            end
                        end

                        R_DROP: begin
                            if (!mode_saucer) begin
                                ride_n = R_IDLE;
                                lock_n = 1'b0;
                            end else if (count_q >= speed_q) begin
                                // Step instant: arriving on the cube (or already on it) lands.
                                count_n = 32'd0;
                                xy_n    = stepped_xy;
                                if (stepped_xy == e_XY0_qb)
                                    ride_n = R_LAND;
                            end else begin
                                count_n = count_q + 32'd1;
                            end
                        end

                        R_LAND: begin
                            if (count_q >= LAND_LAST) begin
                                done_n  = 1'b1;
                                armed_n = 1'b0;
                                ride_n  = R_IDLE;
                                lock_n  = 1'b0;
                                count_n = 32'd0;
                            end else begin
                                count_n = count_q + 32'd1;
                            end
                        end

                        default: begin
                            ride_n = R_IDLE;
                            lock_n = 1'b0;
                        end
                    endcase
                end
            end

            default: game_n = G_RESUME;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // values computed for this edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            game_q    <= G_RESUME;
            ride_q    <= R_IDLE;
            ride_xy   <= 21'd0;
            qb_lock   <= 1'b0;
            ride_done <= 1'b0;
            count_q   <= 32'd0;
            speed_q   <= DF_SPEED;
            armed_q   <= 1'b1;
        end else begin
            game_q    <= game_n;
            ride_q    <= ride_n;
            ride_xy   <= xy_n;
            qb_lock   <= lock_n;
            ride_done <= done_n;
            count_q   <= count_n;
            speed_q   <= speed_n;
            armed_q   <= armed_n;
        end
    end

    assign ride_state = ride_q;

endmodule

// File: tb/tb_saucer_ride_ctrl.sv
// Directed bench for saucer_ride_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_saucer_ride_ctrl;

    logic        clk;
    logic        reset;
    logic        e_pause_qb;
    logic        e_resume_qb;
    logic        e_start_qb;
    logic [31:0] e_speed_qb;
    logic [20:0] e_XY0_qb;
    logic [20:0] soucoupe_xy;
    logic        qb_on_sc;
    logic        done_move_sc;
    logic        mode_saucer;
    logic [1:0]  state_sc;
    logic [20:0] ride_xy;
    logic        qb_lock;
    logic        ride_done;
    logic [2:0]  ride_state;

    int n_tests = 0;
    int n_fail  = 0;

    saucer_ride_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .e_pause_qb   (e_pause_qb),
        .e_resume_qb  (e_resume_qb),
        .e_start_qb   (e_start_qb),
        .e_speed_qb   (e_speed_qb),
        .e_XY0_qb     (e_XY0_qb),
        .soucoupe_xy  (soucoupe_xy),
        .qb_on_sc     (qb_on_sc),
        .done_move_sc (done_move_sc),
        .mode_saucer  (mode_saucer),
        .state_sc     (state_sc),
        .ride_xy      (ride_xy),
        .qb_lock      (qb_lock),
        .ride_done    (ride_done),
        .ride_state   (ride_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] xy(input int x, input int y);
        return {11'(x), 10'(y)};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_xy"},    32'(ride_xy),    32'd0);
        check({tag, "_lock"},  32'(qb_lock),    32'd0);
        check({tag, "_done"},  32'(ride_done),  32'd0);
        check({tag, "_state"}, 32'(ride_state), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        e_pause_qb   = 1'b0;
        e_resume_qb  = 1'b0;
        e_start_qb   = 1'b0;
        e_speed_qb   = 32'd3;
        e_XY0_qb     = xy(82, 148);
        soucoupe_xy  = 21'd0;
        qb_on_sc     = 1'b0;
        done_move_sc = 1'b0;
        mode_saucer  = 1'b0;
        state_sc     = 2'd0;

        step(2);
        check_idle_outputs("reset");
        reset = 1'b0;
        step(1);

        // Board and follow the saucer with HOVER offset, one cycle behind.
        mode_saucer = 1'b1;
        qb_on_sc    = 1'b1;
        state_sc    = 2'd1;
        soucoupe_xy = xy(100, 200);
        step(1);
        check("board_state", 32'(ride_state), 32'd1);
        check("board_lock",  32'(qb_lock),    32'd1);
        check("board_xy",    32'(ride_xy),    32'(xy(100, 192)));
        soucoupe_xy = xy(80, 158);
        step(1);
        check("follow_xy", 32'(ride_xy), 32'(xy(80, 150)));

        // Drop to {82,148} with speed 3: one step every 4 cycles.
        state_sc = 2'd2;
        step(1);
        check("drop_enter", 32'(ride_state), 32'd2);
        step(3);
        check("drop_wait1", 32'(ride_xy), 32'(xy(80, 150)));
        step(1);
        check("drop_step1", 32'(ride_xy), 32'(xy(81, 149)));
        step(3);
        check("drop_wait2", 32'(ride_xy), 32'(xy(81, 149)));
        step(1);
        check("drop_step2", 32'(ride_xy),    32'(xy(82, 148)));
        check("land_enter", 32'(ride_state), 32'd3);
        step(15);
        check("land_hold_state", 32'(ride_state), 32'd3);
        check("land_hold_done",  32'(ride_done),  32'd0);
        check("land_hold_lock",  32'(qb_lock),    32'd1);
        step(1);
        check("done_pulse", 32'(ride_done),  32'd1);
        check("done_state", 32'(ride_state), 32'd0);
        check("done_lock",  32'(qb_lock),    32'd0);
        check("done_xy",    32'(ride_xy),    32'(xy(82, 148)));

        // Re-arm: still on the parked saucer must not re-board.
        state_sc = 2'd1;
        step(1);
        check("done_single", 32'(ride_done), 32'd0);
        step(2);
        check("rearm_blocked", 32'(ride_state), 32'd0);
        qb_on_sc = 1'b0;
        step(1);
        check("rearm_off", 32'(ride_state), 32'd0);
        qb_on_sc = 1'b1;
        step(1);
        check("rearm_ride", 32'(ride_state), 32'd1);
        check("rearm_xy",   32'(ride_xy),    32'(xy(80, 150)));

        // Pause mid-drop for 50 cycles; the count resumes where it stopped.
        e_XY0_qb = xy(84, 150);
        state_sc = 2'd2;
        step(1);
        check("p_drop", 32'(ride_state), 32'd2);
        step(2);
        e_pause_qb = 1'b1;
        step(1);
        e_pause_qb = 1'b0;
        step(50);
        check("p_hold_xy",    32'(ride_xy),    32'(xy(80, 150)));
        check("p_hold_state", 32'(ride_state), 32'd2);
        e_resume_qb = 1'b1;
        step(1);
        e_resume_qb = 1'b0;
        step(1);
        check("p_resume_wait", 32'(ride_xy), 32'(xy(80, 150)));
        step(1);
        check("p_resume_step", 32'(ride_xy), 32'(xy(81, 150)));

        // Abort from DROP: no completion pulse, position held.
        mode_saucer = 1'b0;
        step(1);
        check("ab_drop_state", 32'(ride_state), 32'd0);
        check("ab_drop_lock",  32'(qb_lock),    32'd0);
        check("ab_drop_done",  32'(ride_done),  32'd0);
        check("ab_drop_xy",    32'(ride_xy),    32'(xy(81, 150)));
        step(1);
        check("ab_drop_done2", 32'(ride_done), 32'd0);

        // Saturating y: centre above HOVER clamps to 0, exact HOVER gives 0.
        mode_saucer = 1'b1;
        state_sc    = 2'd1;
        soucoupe_xy = xy(50, 5);
        step(1);
        check("sat_state", 32'(ride_state), 32'd1);
        check("sat_y5",    32'(ride_xy),    32'(xy(50, 0)));
        soucoupe_xy = xy(50, 8);
        step(1);
        check("sat_y8", 32'(ride_xy), 32'(xy(50, 0)));
        soucoupe_xy = xy(50, 9);
        step(1);
        check("sat_y9", 32'(ride_xy), 32'(xy(50, 1)));
        mode_saucer = 1'b0;
        step(1);
        check("ab_ride_state", 32'(ride_state), 32'd0);
        check("ab_ride_lock",  32'(qb_lock),    32'd0);
        check("ab_ride_done",  32'(ride_done),  32'd0);
        check("ab_ride_xy",    32'(ride_xy),    32'(xy(50, 1)));

        // Reset mid-drop clears everything immediately; first cycle after is IDLE.
        mode_saucer = 1'b1;
        step(1);
        check("r_ride", 32'(ride_state), 32'd1);
        state_sc = 2'd2;
        step(1);
        check("r_drop", 32'(ride_state), 32'd2);
        step(2);
        reset = 1'b1;
        #1;
        check_idle_outputs("r_async");
        step(1);
        reset = 1'b0;
        step(1);
        check_idle_outputs("r_post");

        // Pause with resume and start both high: resume wins, the ride continues.
        state_sc = 2'd1;
        step(1);
        check("b_ride", 32'(ride_state), 32'd1);
        state_sc = 2'd2;
        step(1);
        check("b_drop", 32'(ride_state), 32'd2);
        e_pause_qb = 1'b1;
        step(1);
        e_pause_qb  = 1'b0;
        e_resume_qb = 1'b1;
        e_start_qb  = 1'b1;
        step(1);
        e_resume_qb = 1'b0;
        e_start_qb  = 1'b0;
        step(1);
        check("b_state", 32'(ride_state), 32'd2);
        check("b_xy",    32'(ride_xy),    32'(xy(50, 1)));

        // Restart from pause: one cycle later every output is back at its reset value.
        e_pause_qb = 1'b1;
        step(1);
        e_pause_qb = 1'b0;
        e_start_qb = 1'b1;
        step(1);
        e_start_qb = 1'b0;
        check("s_held", 32'(ride_state), 32'd2);
        step(1);
        check_idle_outputs("s_restart");
        step(1);
        check("s_idle", 32'(ride_state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
